// File: rtl/simon_key_scheduler.sv
// Simon key schedule generator: loads an M-word master key, then streams the
// T round keys one per handshake from an M-word rolling register.
module simon_key_scheduler #(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [N*M-1:0] key,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [N-1:0]   rk,
  output logic [7:0]     rk_idx,
  output logic           rk_last,
  output logic           busy
);

  function automatic int rounds_for(input int n, input int m);
    int r;
    r = 0;
    if      (n == 16 && m == 4) r = 32;
    else if (n == 24 && m == 3) r = 36;
    else if (n == 24 && m == 4) r = 36;
    else if (n == 32 && m == 3) r = 42;
    else if (n == 32 && m == 4) r = 44;
    else if (n == 48 && m == 2) r = 52;
    else if (n == 48 && m == 3) r = 54;
    else if (n == 64 && m == 2) r = 68;
    else if (n == 64 && m == 3) r = 69;
    else if (n == 64 && m == 4) r = 72;
    return r;
  endfunction

  function automatic int zsel_for(input int n, input int m);
    int s;
    s = 0;
    if      (n == 24 && m == 4) s = 1;
    else if (n == 32 && m == 3) s = 2;
    else if (n == 32 && m == 4) s = 3;
    else if (n == 48 && m == 2) s = 2;
    else if (n == 48 && m == 3) s = 3;
    else if (n == 64 && m == 2) s = 2;
    else if (n == 64 && m == 3) s = 3;
    else if (n == 64 && m == 4) s = 4;
    return s;
  endfunction

  localparam int T  = rounds_for(N, M);
  localparam int ZS = zsel_for(N, M);

  // z constants written MSB-first so that z[i] is bit (61 - i)
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
  localparam logic [61:0] Z  = (ZS == 0) ? Z0 : (ZS == 1) ? Z1 : (ZS == 2) ? Z2 :
                               (ZS == 3) ? Z3 : Z4;
  localparam logic [7:0]  LAST = 8'(T - 1);

  if (T == 0) begin : g_illegal
    $error("simon_key_scheduler: unsupported (N, M) pair");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, state_next;
  logic [N-1:0] w [M];
  logic [7:0]   cnt;
  logic [5:0]   zp;
  logic         load, advance, z_bit;
  logic [N-1:0] t, new_word;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: if (key_valid) begin
        load       = 1'b1;
        state_next = RUN;
      end
      RUN: if (rk_ready) begin
        advance = 1'b1;
        if (cnt == LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign z_bit = Z[6'd61 - zp];

  // One Simon key-expansion step on the rolling window, including the z bit
  always_comb begin
    t = {w[M-1][2:0], w[M-1][N-1:3]};
    if (M == 4) t = t ^ w[1];
    t = t ^ {t[0], t[N-1:1]};
    new_word = ~w[0] ^ t ^ {{(N-2){1'b0}}, 2'b11} ^ {{(N-1){1'b0}}, z_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < M; j++) w[j] <= '0;
      cnt <= '0;
      zp  <= '0;
    end else if (load) begin
      for (int j = 0; j < M; j++) w[j] <= key[N*j +: N];
      cnt <= '0;
      zp  <= '0;
    end else if (advance) begin
      for (int j = 0; j < M-1; j++) w[j] <= w[j+1];
      w[M-1] <= new_word;
      cnt    <= cnt + 8'd1;
      zp     <= (zp == 6'd61) ? 6'd0 : zp + 6'd1;
    end
  end

  assign key_ready = (state == IDLE);
  assign rk_valid  = (state == RUN);
  assign busy      = (state == RUN);
  assign rk_last   = (state == RUN) && (cnt == LAST);
  assign rk        = w[0];
  assign rk_idx    = cnt;

endmodule

// File: tb/tb_simon_key_scheduler.sv
// Scoreboard bench for simon_key_scheduler: Simon32/64 reference, backpressure,
// z wrap on Simon128/256, all ten configurations, re-key blocking and reset.
module tb_simon_key_scheduler;

  localparam logic [63:0] REF_KEY = 64'h1918_1110_0908_0100;
  localparam int CN [10] = '{16, 24, 24, 32, 32, 48, 48, 64, 64, 64};
  localparam int CM [10] = '{ 4,  3,  4,  3,  4,  2,  3,  2,  3,  4};
  localparam int CT [10] = '{32, 36, 36, 42, 44, 52, 54, 68, 69, 72};
  localparam int CZ [10] = '{ 0,  0,  1,  2,  3,  2,  3,  2,  3,  4};

  logic        clk = 1'b0;
  logic        rst;
  int          checks, failures;

  logic        key_valid, key_ready, rk_valid, rk_ready, rk_last, busy;
  logic [63:0] key;
  logic [15:0] rk;
  logic [7:0]  rk_idx;

  logic         w_valid, w_kready, w_rkv, w_last, w_busy;
  logic [255:0] w_key;
  logic [63:0]  w_rk;
  logic [7:0]   w_idx;

  logic         all_valid, all_arm;
  logic [255:0] all_key;
  wire  [79:0]  all_hs;
  wire  [79:0]  all_bad;

  logic [15:0] exp_q [$];
  logic [15:0] log_rk [32];
  logic [15:0] ref_log [32];

  always #5 clk = ~clk;

  simon_key_scheduler #(.N(16), .M(4)) u_dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_idx(rk_idx),
    .rk_last(rk_last), .busy(busy));

  simon_key_scheduler #(.N(64), .M(4)) u_wrap (
    .clk(clk), .rst(rst), .key_valid(w_valid), .key_ready(w_kready), .key(w_key),
    .rk_valid(w_rkv), .rk_ready(1'b1), .rk(w_rk), .rk_idx(w_idx),
    .rk_last(w_last), .busy(w_busy));

  function automatic bit zbit(input int s, input int j);
    logic [61:0] z;
    case (s)
      0: z = 62'b11111010001001010110000111001101111101000100101011000011100110;
      1: z = 62'b10001110111110010011000010110101000111011111001001100001011010;
      2: z = 62'b10101111011100000011010010011000101000010001111110010110110011;
      3: z = 62'b11011011101011000110010111100000010010001010011100110100001111;
      default: z = 62'b11010001111001101011011000100000010111000011001010010011101111;
    endcase
    return z[61 - j];
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
    logic [63:0] mask;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction

  // Golden model: expands the whole key sequence up to idx from the master key
  function automatic logic [63:0] model_rk(input int n, input int m, input int zs,
                                           input logic [255:0] k, input int idx);
    logic [63:0] kw [80];
    logic [63:0] mask, tmp;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    for (int i = 0; i < m; i++) kw[i] = k[n*i +: 64] & mask;
    for (int i = m; i <= idx; i++) begin
      tmp = ror(kw[i-1], 3, n);
      if (m == 4) tmp = tmp ^ kw[i-3];
      tmp = tmp ^ ror(tmp, 1, n);
      kw[i] = (~kw[i-m] & mask) ^ tmp ^ 64'd3 ^ {63'd0, zbit(zs, (i - m) % 62)};
    end
    return kw[idx];
  endfunction

  for (genvar g = 0; g < 10; g++) begin : g_cfg
    localparam int GN = CN[g];
    localparam int GM = CM[g];
    logic          c_kready, c_valid, c_last, c_busy;
    logic [GN-1:0] c_rk;
    logic [7:0]    c_idx;
    int            c_hs = 0;
    int            c_bad = 0;

    simon_key_scheduler #(.N(GN), .M(GM)) u_cfg (
      .clk(clk), .rst(rst), .key_valid(all_valid), .key_ready(c_kready),
      .key(all_key[GN*GM-1:0]), .rk_valid(c_valid), .rk_ready(1'b1), .rk(c_rk),
      .rk_idx(c_idx), .rk_last(c_last), .busy(c_busy));

    always @(negedge clk) begin
      if (all_arm && c_valid) begin
        if (c_hs >= 80 || 64'(c_rk) !== model_rk(GN, GM, CZ[g], all_key, c_hs) ||
            c_idx !== 8'(c_hs) || c_last !== (c_hs == CT[g] - 1) || c_busy !== 1'b1 ||
            c_kready !== 1'b0)
          c_bad <= c_bad + 1;
        c_hs <= c_hs + 1;
      end
    end

    assign all_hs[g*8 +: 8]  = 8'(c_hs);
    assign all_bad[g*8 +: 8] = 8'(c_bad);
  end

  task automatic load_key(input logic [63:0] k);
    logic [63:0] m;
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL load_ready: key_ready=%b required 1", key_ready);
    end
    key = k;
    key_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      m = model_rk(16, 4, 0, {192'd0, k}, i);
      exp_q.push_back(m[15:0]);
    end
    @(posedge clk);
    #1 key_valid = 1'b0;
  endtask

  // Consumes the main stream, popping the scoreboard on each handshake
  task automatic drain_stream(input bit stall, input int stop_at, input bit inject,
                              input logic [63:0] inject_key, output int hs);
    int          cyc;
    logic        prev_stall;
    logic [15:0] prev_rk, exp;
    logic [7:0]  prev_idx;
    hs = 0; cyc = 0; prev_stall = 1'b0; prev_rk = '0; prev_idx = '0;
    while (hs < 32 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (hs == stop_at) break;
      if (inject && hs == 5) begin
        key = inject_key;
        key_valid = 1'b1;
      end
      checks++;
      if (rk_valid !== 1'b1 || key_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL run_flags: rk_valid=%b key_ready=%b busy=%b required 1 0 1",
                 rk_valid, key_ready, busy);
      end
      if (prev_stall) begin
        checks++;
        if (rk !== prev_rk || rk_idx !== prev_idx) begin
          failures++;
          $display("[TB] FAIL stall_hold: rk=%h idx=%0d required %h idx %0d",
                   rk, rk_idx, prev_rk, prev_idx);
        end
      end
      rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_ready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (rk !== exp) begin
          failures++;
          $display("[TB] FAIL rk: got %h required %h at handshake %0d", rk, exp, hs);
        end
        checks++;
        if (rk_idx !== 8'(hs)) begin
          failures++;
          $display("[TB] FAIL rk_idx: got %0d required %0d", rk_idx, hs);
        end
        checks++;
        if (rk_last !== (hs == 31)) begin
          failures++;
          $display("[TB] FAIL rk_last: got %b at handshake %0d", rk_last, hs);
        end
        log_rk[hs] = rk;
        hs++;
      end
      prev_stall = rk_valid && !rk_ready;
      prev_rk = rk;
      prev_idx = rk_idx;
    end
    if (hs < 32 && hs != stop_at) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: handshakes=%0d required 32", hs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 || rk_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: key_ready=%b rk_valid=%b busy=%b rk_last=%b required 1 0 0 0",
               key_ready, rk_valid, busy, rk_last);
    end
    checks++;
    if (rk !== 16'h0 || rk_idx !== 8'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: rk=%h rk_idx=%0d required 0 0", rk, rk_idx);
    end
  endtask

  task automatic test_simon32_reference();
    int hs;
    logic [15:0] lits [5];
    lits = '{16'h0100, 16'h0908, 16'h1110, 16'h1918, 16'h71C3};
    load_key(REF_KEY);
    drain_stream(1'b0, -1, 1'b0, 64'd0, hs);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_rk[i] !== lits[i]) begin
        failures++;
        $display("[TB] FAIL ref_literal: rk[%0d]=%h required %h", i, log_rk[i], lits[i]);
      end
    end
    ref_log = log_rk;
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL end_of_stream: key_ready=%b rk_valid=%b busy=%b required 1 0 0",
               key_ready, rk_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    int hs, diffs;
    load_key(REF_KEY);
    drain_stream(1'b1, -1, 1'b0, 64'd0, hs);
    rk_ready = 1'b1;
    checks++;
    if (hs !== 32) begin
      failures++;
      $display("[TB] FAIL bp_handshakes: got %0d required 32", hs);
    end
    diffs = 0;
    for (int i = 0; i < 32; i++) if (log_rk[i] !== ref_log[i]) diffs++;
    checks++;
    if (diffs != 0) begin
      failures++;
      $display("[TB] FAIL bp_sequence: %0d keys differ from unstalled run, required 0", diffs);
    end
    @(negedge clk);
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_extra: rk_valid=%b key_ready=%b required 0 1", rk_valid, key_ready);
    end
  endtask

  task automatic test_key_ignored();
    int hs;
    logic [63:0] ka, kb, m;
    ka = {$urandom(), $urandom()};
    kb = ka ^ 64'hA5A5_0F0F_3C3C_FFFF;
    load_key(ka);
    drain_stream(1'b0, -1, 1'b1, kb, hs);
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL rekey_idle: key_ready=%b rk_valid=%b queued=%0d required 1 0 0",
               key_ready, rk_valid, exp_q.size());
    end
    for (int i = 0; i < 32; i++) begin
      m = model_rk(16, 4, 0, {192'd0, kb}, i);
      exp_q.push_back(m[15:0]);
    end
    @(posedge clk);
    #1 key_valid = 1'b0;
    drain_stream(1'b0, -1, 1'b0, 64'd0, hs);
    checks++;
    if (hs !== 32) begin
      failures++;
      $display("[TB] FAIL rekey_stream: handshakes=%0d required 32", hs);
    end
    @(negedge clk);
  endtask

  task automatic test_z_wrap();
    int hs, cyc;
    logic [255:0] k;
    logic [63:0]  wq [$];
    logic [63:0]  wlog [72];
    logic [63:0]  exp, tz;
    k = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    w_key = k;
    w_valid = 1'b1;
    for (int i = 0; i < 72; i++) wq.push_back(model_rk(64, 4, 4, k, i));
    @(posedge clk);
    #1 w_valid = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 72 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (w_rkv) begin
        exp = wq.pop_front();
        checks++;
        if (w_rk !== exp || w_idx !== 8'(hs) || w_last !== (hs == 71) || w_busy !== 1'b1) begin
          failures++;
          $display("[TB] FAIL wrap_rk: rk=%h idx=%0d last=%b required %h idx %0d",
                   w_rk, w_idx, w_last, exp, hs);
        end
        wlog[hs] = w_rk;
        hs++;
      end
    end
    checks++;
    if (hs != 72) begin
      failures++;
      $display("[TB] FAIL wrap_count: handshakes=%0d required 72", hs);
    end else begin
      for (int c = 0; c < 2; c++) begin
        int i;
        i = (c == 0) ? 66 : 71;
        tz = ror(wlog[i-1], 3, 64) ^ wlog[i-3];
        tz = tz ^ ror(tz, 1, 64);
        tz = wlog[i] ^ ~wlog[i-4] ^ tz ^ 64'd3;
        checks++;
        if (tz !== ((c == 0) ? 64'd1 : 64'd0)) begin
          failures++;
          $display("[TB] FAIL wrap_zbit: idx %0d z term=%h required %0d", i, tz, (c == 0) ? 1 : 0);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (w_kready !== 1'b1 || w_rkv !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap_end: key_ready=%b rk_valid=%b required 1 0", w_kready, w_rkv);
    end
  endtask

  task automatic test_all_configs();
    all_key = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    all_valid = 1'b1;
    all_arm = 1'b1;
    @(posedge clk);
    #1 all_valid = 1'b0;
    repeat (80) @(negedge clk);
    for (int g = 0; g < 10; g++) begin
      checks++;
      if (all_hs[g*8 +: 8] !== 8'(CT[g])) begin
        failures++;
        $display("[TB] FAIL cfg_count: N=%0d M=%0d streamed %0d required %0d",
                 CN[g], CM[g], all_hs[g*8 +: 8], CT[g]);
      end
      checks++;
      if (all_bad[g*8 +: 8] !== 8'd0) begin
        failures++;
        $display("[TB] FAIL cfg_model: N=%0d M=%0d bad keys=%0d required 0",
                 CN[g], CM[g], all_bad[g*8 +: 8]);
      end
    end
    all_arm = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    int hs;
    load_key({$urandom(), $urandom()});
    drain_stream(1'b0, 10, 1'b0, 64'd0, hs);
    checks++;
    if (rk_idx !== 8'd10 || rk_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pre_reset: rk_idx=%0d rk_valid=%b required 10 1", rk_idx, rk_valid);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0 || rk_idx !== 8'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset: rk_valid=%b key_ready=%b busy=%b idx=%0d required 0 1 0 0",
               rk_valid, key_ready, busy, rk_idx);
    end
    exp_q.delete();
    load_key({$urandom(), $urandom()});
    drain_stream(1'b0, -1, 1'b0, 64'd0, hs);
    checks++;
    if (hs !== 32) begin
      failures++;
      $display("[TB] FAIL post_reset_stream: handshakes=%0d required 32", hs);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; key_valid = 1'b0; key = '0; rk_ready = 1'b1;
    w_valid = 1'b0; w_key = '0;
    all_valid = 1'b0; all_key = '0; all_arm = 1'b0;
    test_reset();
    test_simon32_reference();
    test_backpressure();
    test_key_ignored();
    test_z_wrap();
    test_all_configs();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
